plab4_net_router_output_ctrl: RTL
=================================

Name: plab4_net_router_output_ctrl

Overview:
Output-port control for one plab4 ring router; it is the grant side of the req/grant interface driven by each router input controller.
- Takes one-hot route requests from the three input controllers aimed at this output.
- Arbitrates round-robin, issues one-hot grants and muxes the granted message into a one-entry output staging register.
- The staging register drives the outgoing val/rdy channel toward the neighbour router or terminal.

Parameters:
p_msg_nbits, 44, width of one network message (payload + opaque + src + dest)
p_num_reqs, 3, number of requesters; fixed at 3, other values unsupported

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
reqs  input  3  per-input request for this output; bit i from input controller i, each held until granted
in_msg  input  3*p_msg_nbits  concatenated input messages; input i occupies bits [(i+1)*p_msg_nbits-1 : i*p_msg_nbits]
grants  output  3  one-hot (or zero) grant; grants[i]=1 means input i's message is consumed this cycle
out_val  output  1  staging register holds a valid message
out_rdy  input  1  downstream accepts message this cycle
out_msg  output  p_msg_nbits  staged message

Behaviour:
- Reset (reset=0, async): full=0, out_val=0, out_msg=0, grants=0, priority pointer=0 (input 0 highest).
- accept = !full || (out_val && out_rdy). This is a pipelined enqueue: the register may be drained and refilled in the same cycle.
- grants are combinational from reqs, priority pointer and accept. When accept=0, grants=3'b000.
- When accept=1, grant the first requester found in circular order starting at the pointer: ptr, ptr+1, ptr+2 (mod 3).
- At most one grant bit is high. grants=0 when reqs=0.
- A grant means a transfer: the input controller deasserts in_val or moves on. No separate in_val is seen here.
- Rising edge with grant to input g:
  - out_msg <= in_msg slice g
  - full <= 1
  - ptr <= (g+1) mod 3, so g becomes lowest priority.
- Rising edge with out_val && out_rdy and no grant: full <= 0. out_msg holds its last value (don't-care).
- No grant: ptr unchanged. The pointer advances only on an actual grant, never on a blocked request.
- out_val = full. Latency from grant to out_val is 1 cycle.
- Throughput is 1 message/cycle when out_rdy is held high.
- Simultaneous drain and grant: the new message replaces the old one, out_val stays 1, and nothing is lost or duplicated.
- Full and out_rdy=0: grants=0 and all requests stall.
- reqs changing while not granted: legal; arbitration reevaluates every cycle.
- Reset asserted mid-transfer: the staged message is discarded, out_val drops immediately (async) and the pointer returns to 0.
- Pointer encoding is 2 bits; value 3 is unreachable and is treated as 0.

Optional Feature:
PLAB4_NET_ROUTER_OUTPUT_CTRL_BYPASS_EN
- Defined: when full=0 and out_rdy=1, a granted message is presented combinationally in the same cycle.
  - out_val=1 and out_msg = granted in_msg slice.
  - The message is not stored (full stays 0); the pointer still advances.
  - In all other cases behaviour is identical to the default.
- Undefined: no combinational path from reqs/in_msg to out_val/out_msg; minimum latency is 1 cycle.

Decomposition:
- Shared package plab4_net_pkg:
  - port index constants (c_port_0=0, c_port_term=1, c_port_2=2)
  - request/grant width (3)
  - message field widths and offsets used to size p_msg_nbits
- Natural sub-module: plab4_net_rr_arb3, a 3-way round-robin arbiter.
  - Ports: clk, reset, en, reqs, grants.
  - It holds the pointer and updates it only when en && |grants.
- Output control instantiates the arbiter with en=accept and keeps the staging register and mux.

Test Plan:
1. Single request: reset, reqs=3'b010, in_msg slice1=44'hABC, out_rdy=1. Expect grants=3'b010 in cycle 0, out_val=1 and out_msg=44'hABC in cycle 1, then ptr=2.
2. Round-robin fairness: reqs held at 3'b111, out_rdy=1, distinct msgs per input. Expect grant order 0,1,2,0,1,2 over 6 cycles and one out_val per cycle with matching out_msg.
3. Backpressure: fill the register, then out_rdy=0 for 3 cycles with reqs=3'b101. Expect grants=0 and out_msg stable for all 3 cycles; when out_rdy=1 expect grant to the pointer-favoured input that same cycle.
4. Pointer does not advance on stall: ptr=1, register full, out_rdy=0, reqs=3'b011 for 2 cycles, then out_rdy=1. Expect grants=3'b010 (input 1 still first).
5. Async reset mid-operation: full with out_msg=44'h5 and ptr=2; drive reset=0 between clock edges. Expect out_val=0 and grants=0 immediately; after release, reqs=3'b111 grants input 0.
6. Bypass (macro defined): empty, out_rdy=1, reqs=3'b100, slice2=44'h77. Expect out_val=1 and out_msg=44'h77 in the same cycle, and full still 0 next cycle.

Source files
------------

// File: rtl/plab4_net_pkg.sv
// ---------------------------------------------------------------------------
// plab4_net_pkg
// Shared constants for the plab4 ring network router.
//   - Router port indices (clockwise neighbour, terminal, counter-clockwise).
//   - Request/grant vector width.
//   - Network message field widths and bit offsets. The total message width
//     (c_msg_nbits) is derived from these and sizes p_msg_nbits downstream.
// ---------------------------------------------------------------------------
package plab4_net_pkg;

    // Router port indices; bit i of a req/grant vector belongs to port i.
    localparam int c_port_0    = 0;
    localparam int c_port_term = 1;
    localparam int c_port_2    = 2;

    localparam int c_num_reqs  = 3;

    // Message layout, LSB first: payload | opaque | src | dest.
    localparam int c_payload_nbits = 32;
    localparam int c_opaque_nbits  = 8;
    localparam int c_src_nbits     = 2;
    localparam int c_dest_nbits    = 2;

    localparam int c_payload_off = 0;
    localparam int c_opaque_off  = c_payload_off + c_payload_nbits;
    localparam int c_src_off     = c_opaque_off + c_opaque_nbits;
    localparam int c_dest_off    = c_src_off + c_src_nbits;

    localparam int c_msg_nbits   = c_dest_off + c_dest_nbits;

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// ---------------------------------------------------------------------------
// plab4_net_rr_arb3
// Three-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk     - clock, state updates on rising edge
//   reset   - asynchronous, active-low reset; pointer returns to 0
//   en      - arbitration enable; grants are forced to zero when low
//   reqs    - per-requester request bits
//   grants  - one-hot (or zero) grant, combinational from reqs/pointer/en
// The pointer names the highest-priority requester. It moves to one past
// the granted requester, and only when a grant is actually issued.
// ---------------------------------------------------------------------------
module plab4_net_rr_arb3
    import plab4_net_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [c_num_reqs-1:0] reqs,
    output logic [c_num_reqs-1:0] grants
);

    logic [1:0]            ptr_q;
    logic [1:0]            ptr_d;
    logic [1:0]            ptr_eff;
    logic [c_num_reqs-1:0] rot_reqs;
    logic [c_num_reqs-1:0] rot_gnt;
    logic [c_num_reqs-1:0] raw_gnt;

    // Encoding 3 is unreachable; decode it as 0 so a corrupted pointer
    // still arbitrates sensibly.
    assign ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

    always_comb begin
        // Rotate so that bit 0 is the requester the pointer favours.
        case (ptr_eff)
            2'd1:    rot_reqs = {reqs[0], reqs[2], reqs[1]};
            2'd2:    rot_reqs = {reqs[1], reqs[0], reqs[2]};
            default: rot_reqs = reqs;
        endcase

        // Fixed-priority pick on the rotated vector.
        if (rot_reqs[0])      rot_gnt = 3'b001;
        else if (rot_reqs[1]) rot_gnt = 3'b010;
        else if (rot_reqs[2]) rot_gnt = 3'b100;
        else                  rot_gnt = 3'b000;

        // Undo the rotation.
        case (ptr_eff)
            2'd1:    raw_gnt = {rot_gnt[1], rot_gnt[0], rot_gnt[2]};
            2'd2:    raw_gnt = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
            default: raw_gnt = rot_gnt;
        endcase

        // Gating with reset keeps grants low while reset is held, so no
        // input controller believes a transfer happened during reset.
        grants = (en && reset) ? raw_gnt : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grants[c_port_0])    ptr_d = 2'(c_port_term);
        if (grants[c_port_term]) ptr_d = 2'(c_port_2);
        if (grants[c_port_2])    ptr_d = 2'(c_port_0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// ---------------------------------------------------------------------------
// plab4_net_router_output_ctrl
// Output-port control for one plab4 ring router: arbitrates the three input
// controllers' requests round-robin, muxes the granted message into a
// one-entry staging register and presents it on a val/rdy channel.
// Ports:
//   clk      - clock, state updates on rising edge
//   reset    - asynchronous, active-low reset
//   reqs     - request bit i from input controller i, held until granted
//   in_msg   - concatenated input messages, input i at slice i
//   grants   - one-hot (or zero) grant; input i's message consumed this cycle
//   out_val  - outgoing message valid
//   out_rdy  - downstream accepts the outgoing message this cycle
//   out_msg  - outgoing message
// Optional feature macro: PLAB4_NET_ROUTER_OUTPUT_CTRL_BYPASS_EN
//   When defined, a message granted while the register is empty and out_rdy
//   is high is forwarded combinationally in the same cycle without being
//   stored.
// ---------------------------------------------------------------------------
module plab4_net_router_output_ctrl
    import plab4_net_pkg::*;
#(
    parameter int p_msg_nbits = c_msg_nbits,
    parameter int p_num_reqs  = c_num_reqs
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             reqs,
    input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
    output logic [p_num_reqs-1:0]             grants,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [p_msg_nbits-1:0]            out_msg
);

    logic                   full_q;
    logic                   full_d;
    logic [p_msg_nbits-1:0] out_msg_q;
    logic [p_msg_nbits-1:0] out_msg_d;
    logic                   accept;
    logic                   any_grant;
    logic                   bypass;
    logic [p_msg_nbits-1:0] grant_msg;
    logic [p_msg_nbits-1:0] masked_msg [p_num_reqs];

    // Pipelined enqueue: a full register that drains this cycle can refill.
    assign accept    = !full_q || (full_q && out_rdy);
    assign any_grant = |grants;

    plab4_net_rr_arb3 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (accept),
        .reqs   (reqs),
        .grants (grants)
    );

    // Grants are one-hot, so an AND-OR mux selects the granted slice.
    for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_mux
        assign masked_msg[gi] = in_msg[gi*p_msg_nbits +: p_msg_nbits]
                              & {p_msg_nbits{grants[gi]}};
    end

    always_comb begin
        grant_msg = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            grant_msg = grant_msg | masked_msg[i];
        end
    end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_BYPASS_EN
    assign bypass = any_grant && !full_q && out_rdy;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        full_d    = full_q;
        out_msg_d = out_msg_q;
        if (any_grant && !bypass) begin
            full_d    = 1'b1;
            out_msg_d = grant_msg;
        end else if (full_q && out_rdy) begin
            // Drained with nothing to replace it; the stale data stays put.
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= 1'b0;
            out_msg_q <= '0;
        end else begin
            full_q    <= full_d;
            out_msg_q <= out_msg_d;
        end
    end

    assign out_val = full_q || bypass;
    assign out_msg = bypass ? grant_msg : out_msg_q;

endmodule
